// File: rtl/instruction_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding, the fault codes and the instruction size.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    localparam int INST_BYTES = 4;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_ctrl_if.sv
// Bundle of the memory, redirect and decode-handshake signals of the fetch unit.
// The master side is the fetch controller; the slave side is memory plus decode.
interface instruction_fetch_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] Inst_Address;
    logic [31:0]       Instruction;
    logic              Redirect;
    logic [ADDR_W-1:0] Redirect_Target;
    logic              Fetch_Valid;
    logic              Fetch_Ready;
    logic [31:0]       Fetch_Instruction;
    logic [ADDR_W-1:0] Fetch_PC;
    logic [1:0]        Fault;
    logic [31:0]       Fetch_Count;

    modport master (
        output Inst_Address,
        input  Instruction,
        input  Redirect,
        input  Redirect_Target,
        output Fetch_Valid,
        input  Fetch_Ready,
        output Fetch_Instruction,
        output Fetch_PC,
        output Fault,
        output Fetch_Count
    );

    modport slave (
        input  Inst_Address,
        output Instruction,
        output Redirect,
        output Redirect_Target,
        input  Fetch_Valid,
        output Fetch_Ready,
        input  Fetch_Instruction,
        input  Fetch_PC,
        input  Fault,
        input  Fetch_Count
    );
endinterface

// File: rtl/instruction_fetch_ctrl_out_reg.sv
// One-entry holding register for {instruction, pc} towards decode.
// Flush wins over load; with neither asserted the entry holds.
module fetch_out_reg #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              flush,
    input  logic [31:0]       in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc
);

    logic              valid_q, valid_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = in_inst;
            pc_d    = in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign inst  = inst_q;
    assign pc    = pc_q;

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives instruction memory, hands words to decode,
// follows redirects and halts with a fault code on bad fetch addresses.
module instruction_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              MEM_BYTES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_ctrl_if.master bus
);

    // Highest PC whose full word still lies inside the memory.
    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(MEM_BYTES - INST_BYTES);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INST_BYTES);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        fault_q, fault_d;
    logic [31:0]       count_q, count_d;

    logic              out_load;
    logic              out_flush;
    logic              out_valid;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_pc;

    logic              accept;
    logic              slot_free;

    assign accept    = out_valid && bus.Fetch_Ready;
    assign slot_free = !out_valid || bus.Fetch_Ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fault_d   = fault_q;
        out_load  = 1'b0;
        out_flush = 1'b0;
        count_d   = accept ? count_q + 32'd1 : count_q;

        case (state_q)
            FETCH: begin
                if (bus.Redirect) begin
                    out_flush = 1'b1;
                    pc_d      = bus.Redirect_Target;
                    if (!is_word_aligned(bus.Redirect_Target[1:0])) begin
                        state_d = HALT;
                        fault_d = FAULT_MISALIGN;
                    end
                end else if (slot_free) begin
                    if (pc_q <= LAST_PC) begin
                        out_load = 1'b1;
                        pc_d     = pc_q + PC_STEP;
                    end else begin
                        out_flush = 1'b1;
                        state_d   = HALT;
                        fault_d   = FAULT_RANGE;
                    end
                end
            end
            HALT: begin
                out_flush = 1'b1;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            fault_q <= FAULT_NONE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    fetch_out_reg #(
        .ADDR_W (ADDR_W)
    ) u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (out_load),
        .flush   (out_flush),
        .in_inst (bus.Instruction),
        .in_pc   (pc_q),
        .valid   (out_valid),
        .inst    (out_inst),
        .pc      (out_pc)
    );

    assign bus.Inst_Address      = pc_q;
    assign bus.Fetch_Valid       = out_valid;
    assign bus.Fetch_Instruction = out_inst;
    assign bus.Fetch_PC          = out_pc;
    assign bus.Fault             = fault_q;
    assign bus.Fetch_Count       = count_q;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Self-checking bench for instruction_fetch_ctrl: per-cycle vector table plus a
// scoreboard of expected decode transfers, and a short hand-written reset sequence.
module tb_instruction_fetch_ctrl;

    localparam int ADDR_W = 64;
    localparam logic [31:0] W0 = 32'h00508093;
    localparam logic [31:0] W1 = 32'h00608093;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rd;
        logic [63:0] tgt;
        logic        v;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] addr;
        logic [1:0]  flt;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } xfer_t;

    logic clk;
    logic reset;
    logic [31:0] mem [4];

    vec_t  vecs [$];
    xfer_t sb   [$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    instruction_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_fetch_ctrl #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (64'd0),
        .MEM_BYTES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (bus.Inst_Address < 64'd16)
            bus.Instruction = mem[bus.Inst_Address[3:2]];
        else
            bus.Instruction = 32'h0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Accepts are observed mid-cycle; the transfer completes on the next edge.
    always @(negedge clk) begin
        if (!reset && bus.Fetch_Valid && bus.Fetch_Ready) begin
            if (sb.size() == 0) begin
                check("sb unexpected accept", {32'h0, bus.Fetch_Instruction}, 64'hdead);
            end else begin
                xfer_t e;
                e = sb.pop_front();
                check("sb pc", bus.Fetch_PC, e.pc);
                check("sb inst", {32'h0, bus.Fetch_Instruction}, {32'h0, e.inst});
                $display("xfer pc=%0h inst=%08h exp pc=%0h inst=%08h",
                         bus.Fetch_PC, bus.Fetch_Instruction, e.pc, e.inst);
            end
        end
    end

    task automatic add(input logic rst, input logic rdy, input logic rd, input logic [63:0] tgt,
                       input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic [63:0] addr, input logic [1:0] flt, input logic [31:0] cnt);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.rd = rd; t.tgt = tgt;
        t.v = v; t.pc = pc; t.inst = inst; t.addr = addr; t.flt = flt; t.cnt = cnt;
        vecs.push_back(t);
    endtask

    initial begin
        mem[0] = W0; mem[1] = W1; mem[2] = W0; mem[3] = W1;
        reset = 1'b1;
        bus.Fetch_Ready = 1'b0;
        bus.Redirect = 1'b0;
        bus.Redirect_Target = '0;

        //   rst rdy rd tgt     v  pc     inst  addr   flt   cnt
        // streaming to range fault
        add(1, 0, 0, 64'd0,  0, 64'd0,  32'h0, 64'd0,  2'b00, 32'd0);
        add(1, 0, 0, 64'd0,  0, 64'd0,  32'h0, 64'd0,  2'b00, 32'd0);
        add(0, 1, 0, 64'd0,  1, 64'd0,  W0,    64'd4,  2'b00, 32'd0);
        add(0, 1, 0, 64'd0,  1, 64'd4,  W1,    64'd8,  2'b00, 32'd1);
        add(0, 1, 0, 64'd0,  1, 64'd8,  W0,    64'd12, 2'b00, 32'd2);
        add(0, 1, 0, 64'd0,  1, 64'd12, W1,    64'd16, 2'b00, 32'd3);
        add(0, 1, 0, 64'd0,  0, 64'd12, W1,    64'd16, 2'b10, 32'd4);
        add(0, 1, 0, 64'd0,  0, 64'd12, W1,    64'd16, 2'b10, 32'd4);
        // backpressure
        add(1, 0, 0, 64'd0,  0, 64'd0,  32'h0, 64'd0,  2'b00, 32'd0);
        add(0, 1, 0, 64'd0,  1, 64'd0,  W0,    64'd4,  2'b00, 32'd0);
        add(0, 1, 0, 64'd0,  1, 64'd4,  W1,    64'd8,  2'b00, 32'd1);
        add(0, 0, 0, 64'd0,  1, 64'd4,  W1,    64'd8,  2'b00, 32'd1);
        add(0, 0, 0, 64'd0,  1, 64'd4,  W1,    64'd8,  2'b00, 32'd1);
        add(0, 0, 0, 64'd0,  1, 64'd4,  W1,    64'd8,  2'b00, 32'd1);
        add(0, 1, 0, 64'd0,  1, 64'd8,  W0,    64'd12, 2'b00, 32'd2);
        // redirect with flush
        add(1, 0, 0, 64'd0,  0, 64'd0,  32'h0, 64'd0,  2'b00, 32'd0);
        add(0, 0, 0, 64'd0,  1, 64'd0,  W0,    64'd4,  2'b00, 32'd0);
        add(0, 0, 1, 64'd8,  0, 64'd0,  W0,    64'd8,  2'b00, 32'd0);
        add(0, 0, 0, 64'd0,  1, 64'd8,  W0,    64'd12, 2'b00, 32'd0);
        add(0, 1, 0, 64'd0,  1, 64'd12, W1,    64'd16, 2'b00, 32'd1);
        // redirect coincident with accept
        add(1, 0, 0, 64'd0,  0, 64'd0,  32'h0, 64'd0,  2'b00, 32'd0);
        add(0, 1, 0, 64'd0,  1, 64'd0,  W0,    64'd4,  2'b00, 32'd0);
        add(0, 1, 0, 64'd0,  1, 64'd4,  W1,    64'd8,  2'b00, 32'd1);
        add(0, 1, 1, 64'd0,  0, 64'd4,  W1,    64'd0,  2'b00, 32'd2);
        add(0, 1, 0, 64'd0,  1, 64'd0,  W0,    64'd4,  2'b00, 32'd2);
        add(0, 1, 0, 64'd0,  1, 64'd4,  W1,    64'd8,  2'b00, 32'd3);
        // misaligned target, then ignored redirect, then reset recovery
        add(0, 1, 1, 64'd6,  0, 64'd4,  W1,    64'd6,  2'b01, 32'd4);
        add(0, 1, 1, 64'd0,  0, 64'd4,  W1,    64'd6,  2'b01, 32'd4);
        add(1, 1, 0, 64'd0,  0, 64'd0,  32'h0, 64'd0,  2'b00, 32'd0);
        add(0, 1, 0, 64'd0,  1, 64'd0,  W0,    64'd4,  2'b00, 32'd0);
        // reset mid-stream
        add(0, 1, 0, 64'd0,  1, 64'd4,  W1,    64'd8,  2'b00, 32'd1);
        add(0, 1, 0, 64'd0,  1, 64'd8,  W0,    64'd12, 2'b00, 32'd2);
        add(1, 1, 0, 64'd0,  0, 64'd0,  32'h0, 64'd0,  2'b00, 32'd0);
        // out-of-range redirect faults on the following fetch attempt
        add(0, 0, 0, 64'd0,  1, 64'd0,  W0,    64'd4,  2'b00, 32'd0);
        add(0, 0, 1, 64'd20, 0, 64'd0,  W0,    64'd20, 2'b00, 32'd0);
        add(0, 0, 0, 64'd0,  0, 64'd0,  W0,    64'd20, 2'b10, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0 && !vecs[i].rst && vecs[i].rdy && vecs[i-1].v) begin
                xfer_t e;
                e.pc = vecs[i-1].pc;
                e.inst = vecs[i-1].inst;
                sb.push_back(e);
            end
            reset               = vecs[i].rst;
            bus.Fetch_Ready     = vecs[i].rdy;
            bus.Redirect        = vecs[i].rd;
            bus.Redirect_Target = vecs[i].tgt;
            @(posedge clk);
            #1;
            $display("vec %0d: valid=%0b pc=%0h inst=%08h addr=%0h fault=%0b count=%0d",
                     i, bus.Fetch_Valid, bus.Fetch_PC, bus.Fetch_Instruction,
                     bus.Inst_Address, bus.Fault, bus.Fetch_Count);
            check($sformatf("v%0d valid", i), {63'h0, bus.Fetch_Valid}, {63'h0, vecs[i].v});
            check($sformatf("v%0d pc", i), bus.Fetch_PC, vecs[i].pc);
            check($sformatf("v%0d inst", i), {32'h0, bus.Fetch_Instruction}, {32'h0, vecs[i].inst});
            check($sformatf("v%0d addr", i), bus.Inst_Address, vecs[i].addr);
            check($sformatf("v%0d fault", i), {62'h0, bus.Fault}, {62'h0, vecs[i].flt});
            check($sformatf("v%0d count", i), {32'h0, bus.Fetch_Count}, {32'h0, vecs[i].cnt});
        end

        // Hand-written: bounded wait for the first valid after reset, then a stall.
        reset = 1'b1;
        bus.Fetch_Ready = 1'b0;
        bus.Redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        begin
            int waited;
            waited = 0;
            while (!bus.Fetch_Valid && waited < 8) begin
                @(posedge clk);
                #1;
                waited++;
            end
            $display("hand: first valid after %0d cycles", waited);
            check("hand first valid", {63'h0, bus.Fetch_Valid}, 64'd1);
            check("hand first latency", waited, 64'd1);
        end
        check("hand first pc", bus.Fetch_PC, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hand stall addr", bus.Inst_Address, 64'd4);
        check("hand stall count", {32'h0, bus.Fetch_Count}, 64'd0);

        check("sb drained", sb.size(), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_ctrl.md
# instruction_fetch_ctrl

Fetch sequencer for the byte-addressed, combinational-read instruction memory. It owns the program counter and drives the memory's `Inst_Address`. It captures the returned 32-bit `Instruction` into a one-entry output register and presents it to decode over a valid/ready handshake. It also handles control-flow redirects and halts with a fault code on misaligned or out-of-range fetches.

## Interface
- `ADDR_W`, 64: PC / address width.
- `RESET_PC`, 0: PC loaded on reset.
- `MEM_BYTES`, 16: instruction memory size in bytes; must be a multiple of 4.
- `clk` input, 1: clock, rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `Inst_Address` output, ADDR_W: address to instruction memory; always equals the PC register.
- `Instruction` input, 32: memory read data for `Inst_Address`, valid in the same cycle.
- `Redirect` input, 1: branch/jump taken; single-cycle pulse.
- `Redirect_Target` input, ADDR_W: new PC; sampled when `Redirect`=1.
- `Fetch_Valid` output, 1: output register holds an instruction.
- `Fetch_Ready` input, 1: decode accepts this cycle.
- `Fetch_Instruction` output, 32: held instruction word.
- `Fetch_PC` output, ADDR_W: address of the held instruction.
- `Fault` output, 2: 00 none, 01 misaligned target, 10 out of range.
- `Fetch_Count` output, 32: count of accepted transfers; wraps modulo 2^32.

## Operation
- States: FETCH and HALT.
- Reset values: PC=RESET_PC, state FETCH, `Fetch_Valid`=0, `Fetch_Instruction`=0, `Fetch_PC`=0, `Fault`=00, `Fetch_Count`=0.
- Accept: `Fetch_Valid && Fetch_Ready`. Each accept increments `Fetch_Count`.
- Slot free: `!Fetch_Valid || Fetch_Ready`.
- FETCH, no redirect, slot free, PC ≤ MEM_BYTES−4: on the clock edge, capture `Instruction` and PC into the output register, set valid, and set PC ← PC+4.
- FETCH, no redirect, slot free, PC > MEM_BYTES−4: go to HALT, set `Fault`=10, clear valid.
- FETCH, no redirect, `Fetch_Valid` && !`Fetch_Ready`: hold all outputs and the PC.
- Redirect in FETCH: overrides fetch and capture.
  - Clear valid (flush).
  - Set PC ← `Redirect_Target`.
  - If the target is misaligned (bits[1:0]≠0), go to HALT with `Fault`=01 instead.
  - An accept in the same cycle still counts; the flushed entry does not.
- Out-of-range targets are not checked on redirect. They fault on the next fetch attempt.
- HALT: `Fetch_Valid`=0 and `Redirect` is ignored. Only `reset` exits HALT.
- `reset` has priority over all other events, including mid-transfer and in HALT.

## Timing
- First `Fetch_Valid` is high one cycle after the first edge with `reset`=0.
- Throughput: one instruction per cycle while `Fetch_Ready`=1.
- Redirect penalty: one bubble cycle. `Fetch_Valid`=0 in the cycle after `Redirect`; the target instruction is valid the cycle after that.
- `Inst_Address` is driven from a register. There is no combinational path from `Fetch_Ready`, `Redirect` or `Redirect_Target` to `Inst_Address`.
- The only combinational input-to-output dependency is `Instruction` → output-register D input.
- `Fault` is set on the same edge as the HALT entry.
- The PC increment is ADDR_W-bit unsigned. PC wrap-around is impossible because the range check runs before the increment.

## Structure
- Shared package `fetch_pkg`:
  - State enum {FETCH, HALT}.
  - Fault constants FAULT_NONE=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10.
  - INST_BYTES=4.
- Sub-module `fetch_out_reg`: one-entry valid/ready holding register for {instruction, pc}, with load, flush and hold controls.
- Top level: PC register, FSM, range and alignment checks, counter.

## Test plan
Memory is loaded with words 0x00508093, 0x00608093, 0x00508093, 0x00608093 at 0, 4, 8, 12; MEM_BYTES=16.

- **Streaming:** reset for 2 cycles, then `Fetch_Ready`=1 → `Fetch_PC` 0, 4, 8, 12 on consecutive cycles with the words above. Then `Fetch_Valid`=0, `Fault`=10, `Fetch_Count`=4.
- **Backpressure:** `Fetch_Ready`=0 for 3 cycles while `Fetch_PC`=4 → `Fetch_Instruction`=0x00608093, `Inst_Address`=8 and `Fetch_Count` stay stable. Raise ready → next cycle `Fetch_PC`=8.
- **Redirect with flush:** `Redirect`=1, target 8, while `Fetch_PC`=0 and `Fetch_Ready`=0 → next cycle `Fetch_Valid`=0, then `Fetch_PC`=8 / 0x00508093. `Fetch_Count` unchanged by the flushed entry.
- **Redirect with accept:** `Redirect` coincident with an accept at `Fetch_PC`=4 → `Fetch_Count` +1, then `Fetch_PC`=target after one bubble.
- **Misaligned target:** redirect to 6 → `Fault`=01, `Fetch_Valid`=0. A later redirect to 0 is ignored. Reset → `Fault`=00, fetch restarts at 0.
- **Reset mid-stream:** assert `reset` while `Fetch_Valid`=1 at `Fetch_PC`=8 → next cycle `Fetch_Valid`=0, `Inst_Address`=0, `Fetch_Count`=0.
